router_pkt_tx: RTL and testbench

- Packet source for the router input port. It drives `data_in` and `pkt_valid` and obeys the router's `busy` back-pressure.
- Packet format on the wire:
  - Header byte: {len[5:0], addr[1:0]}.
  - `len` payload bytes.
  - One parity byte: XOR of the header and all payload bytes.
- Serves as the stimulus/traffic generator for router integration. Payload is an incrementing pattern from a seed, so receive-side checks are deterministic.

---
 rtl/router_pkt_tx.sv | 153 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header {len,addr}, incrementing payload
// from a seed, then an XOR parity byte, all under busy back-pressure.
module router_pkt_tx #(
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       cmd_addr,
   input  logic [5:0]       cmd_len,
   input  logic [7:0]       cmd_seed,
   input  logic             err_inject,
   input  logic             busy,
   output logic [7:0]       data_out,
   output logic             pkt_valid,
   output logic             cmd_ready,
   output logic             cmd_err,
   output logic             tx_done,
   output logic [CNT_W-1:0] pkt_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_PARITY  = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   // Final parity byte; the flip lets traffic deliberately carry a bad checksum.
   function automatic logic [7:0] parity_byte(input logic [7:0] acc,
                                              input logic [7:0] last,
                                              input logic       flip);
      return acc ^ last ^ {7'b0, flip};
   endfunction

   state_t           state_r;
   logic [7:0]       data_out_r;
   logic             pkt_valid_r;
   logic             cmd_ready_r;
   logic             cmd_err_r;
   logic             tx_done_r;
   logic [CNT_W-1:0] pkt_count_r;
   logic [5:0]       len_r;
   logic [7:0]       seed_r;
   logic             err_r;
   logic [5:0]       remaining_r;
   logic [7:0]       parity_r;
   logic [3:0]       gap_cnt_r;
   logic             cmd_bad_s;

   assign cmd_bad_s = (cmd_len == 6'd0) || (cmd_addr == 2'd3);

   assign data_out  = data_out_r;
   assign pkt_valid = pkt_valid_r;
   assign cmd_ready = cmd_ready_r;
   assign cmd_err   = cmd_err_r;
   assign tx_done   = tx_done_r;
   assign pkt_count = pkt_count_r;

   // Packet sequencer; every output is a register written here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         data_out_r  <= 8'd0;
         pkt_valid_r <= 1'b0;
         cmd_ready_r <= 1'b1;
         cmd_err_r   <= 1'b0;
         tx_done_r   <= 1'b0;
         pkt_count_r <= '0;
         len_r       <= 6'd0;
         seed_r      <= 8'd0;
         err_r       <= 1'b0;
         remaining_r <= 6'd0;
         parity_r    <= 8'd0;
         gap_cnt_r   <= 4'd0;
      end else begin
         cmd_err_r <= 1'b0;
         tx_done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  if (cmd_bad_s) begin
                     cmd_err_r <= 1'b1;
                  end else begin
                     len_r       <= cmd_len;
                     seed_r      <= cmd_seed;
                     err_r       <= err_inject;
                     data_out_r  <= {cmd_len, cmd_addr};
                     pkt_valid_r <= 1'b1;
                     cmd_ready_r <= 1'b0;
                     state_r     <= S_HEADER;
                  end
               end
            end
            S_HEADER: begin
               // data_out_r still holds the header, which seeds the parity.
               if (!busy) begin
                  parity_r    <= data_out_r;
                  remaining_r <= len_r;
                  data_out_r  <= seed_r;
                  state_r     <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (!busy) begin
                  parity_r    <= parity_r ^ data_out_r;
                  remaining_r <= remaining_r - 6'd1;
                  if (remaining_r == 6'd1) begin
                     data_out_r  <= parity_byte(parity_r, data_out_r, err_r);
                     pkt_valid_r <= 1'b0;
                     state_r     <= S_PARITY;
                  end else begin
                     data_out_r <= data_out_r + 8'd1;
                  end
               end
            end
            S_PARITY: begin
               if (!busy) begin
                  tx_done_r   <= 1'b1;
                  pkt_count_r <= pkt_count_r + CNT_W'(1);
                  data_out_r  <= 8'd0;
                  gap_cnt_r   <= 4'd0;
                  if (GAP_CYCLES == 0) begin
                     cmd_ready_r <= 1'b1;
                     state_r     <= S_IDLE;
                  end else begin
                     state_r <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  cmd_ready_r <= 1'b1;
                  state_r     <= S_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 4'd1;
               end
            end
            default: begin
               data_out_r  <= 8'd0;
               pkt_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bytes are queued when a command is
// issued and compared as the router side consumes them.
module tb_router_pkt_tx;

   localparam int GAP = 2;
   localparam int CW  = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    cmd_addr = 2'd0;
   logic [5:0]    cmd_len = 6'd0;
   logic [7:0]    cmd_seed = 8'd0;
   logic          err_inject = 1'b0;
   logic          busy = 1'b0;
   logic [7:0]    data_out;
   logic          pkt_valid;
   logic          cmd_ready;
   logic          cmd_err;
   logic          tx_done;
   logic [CW-1:0] pkt_count;

   router_pkt_tx #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_seed(cmd_seed), .err_inject(err_inject), .busy(busy),
      .data_out(data_out), .pkt_valid(pkt_valid), .cmd_ready(cmd_ready),
      .cmd_err(cmd_err), .tx_done(tx_done), .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          hdr_cyc = 0;
   int          par_cyc = 0;
   int          hdr_cnt = 0;
   bit          in_pkt = 1'b0;
   bit          hdr_noted = 1'b0;
   bit          tx_exp = 1'b0;
   bit          err_window = 1'b0;
   bit          rand_busy = 1'b0;
   logic [CW-1:0] model_cnt = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic push_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input logic e);
      logic [7:0] p;
      logic [7:0] d;
      p = {l, a};
      exp_q.push_back('{data: p, valid: 1'b1});
      d = s;
      for (int i = 0; i < int'(l); i++) begin
         exp_q.push_back('{data: d, valid: 1'b1});
         p = p ^ d;
         d = d + 8'd1;
      end
      exp_q.push_back('{data: p ^ {7'b0, e}, valid: 1'b0});
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cmd_ready && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      if (!cmd_ready) check_val("cmd_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input logic e);
      push_pkt(a, l, s, e);
      wait_ready();
      cmd_addr = a; cmd_len = l; cmd_seed = s; err_inject = e; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; err_inject = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_pkt) && n < 400) begin
         @(posedge clock); #1;
         busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
         n++;
      end
      busy = 1'b0;
      if (exp_q.size() != 0 || in_pkt) check_val("packet_timeout", 32'd0, 32'd1);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic send_illegal(input logic [1:0] a, input logic [5:0] l);
      wait_ready();
      err_window = 1'b1;
      cmd_addr = a; cmd_len = l; cmd_seed = 8'h55; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check_val("illegal_cmd_err", {31'd0, cmd_err}, 32'd1);
      check_val("illegal_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("illegal_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      @(posedge clock); #1;
      check_val("illegal_err_single", {31'd0, cmd_err}, 32'd0);
      check_val("illegal_ready_after", {31'd0, cmd_ready}, 32'd1);
      err_window = 1'b0;
   endtask

   // Router-side monitor: consumes bytes exactly when the DUT will see busy low.
   always @(negedge clock) begin
      exp_t e;
      cyc++;
      if (!reset) begin
         check_val("tx_done", {31'd0, tx_done}, {31'd0, tx_exp});
         if (tx_done) check_val("pkt_count", {16'd0, pkt_count}, {16'd0, model_cnt});
         tx_exp = 1'b0;
         if (!err_window) check_val("cmd_err_quiet", {31'd0, cmd_err}, 32'd0);
         if (pkt_valid && !in_pkt && !hdr_noted) begin
            hdr_noted = 1'b1;
            hdr_cyc = cyc;
            hdr_cnt++;
         end
         if (pkt_valid || in_pkt) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else if (busy) begin
               check_val("hold_data", {24'd0, data_out}, {24'd0, exp_q[0].data});
               check_val("hold_valid", {31'd0, pkt_valid}, {31'd0, exp_q[0].valid});
            end else begin
               e = exp_q.pop_front();
               check_val("byte", {24'd0, data_out}, {24'd0, e.data});
               check_val("valid", {31'd0, pkt_valid}, {31'd0, e.valid});
               in_pkt = e.valid;
               if (!e.valid) begin
                  tx_exp = 1'b1;
                  model_cnt = model_cnt + 16'd1;
                  par_cyc = cyc;
                  hdr_noted = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int n;
      int h0;
      repeat (2) @(posedge clock);
      #1;
      check_val("rst_data_out", {24'd0, data_out}, 32'd0);
      check_val("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
      check_val("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check_val("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // basic packet 0D 10 11 12 / 1E
      send_cmd(2'd1, 6'd3, 8'h10, 1'b0);
      wait_done();

      // back-pressure while 0x11 is presented
      send_cmd(2'd1, 6'd3, 8'h10, 1'b0);
      n = 0;
      while (!(pkt_valid && data_out == 8'h11) && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("bp_reached_0x11", {24'd0, data_out}, 32'h11);
      busy = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_val("bp_still_0x11", {24'd0, data_out}, 32'h11);
      busy = 1'b0;
      wait_done();

      // parity corruption
      send_cmd(2'd1, 6'd3, 8'h10, 1'b1);
      wait_done();

      // illegal commands
      send_illegal(2'd3, 6'd5);
      send_illegal(2'd0, 6'd0);
      send_illegal(2'd3, 6'd0);

      // random back-pressure
      rand_busy = 1'b1;
      send_cmd(2'd0, 6'd7, 8'hC3, 1'b0);
      wait_done();
      rand_busy = 1'b0;

      // max length with seed wrap, start held for two back-to-back packets
      push_pkt(2'd2, 6'd63, 8'hF0, 1'b0);
      push_pkt(2'd2, 6'd63, 8'hF0, 1'b0);
      wait_ready();
      h0 = hdr_cnt;
      cmd_addr = 2'd2; cmd_len = 6'd63; cmd_seed = 8'hF0; err_inject = 1'b0; start = 1'b1;
      n = 0;
      while (hdr_cnt < h0 + 2 && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      start = 1'b0;
      check_val("two_headers_seen", hdr_cnt - h0, 32'd2);
      check_val("gap_min", {31'd0, (hdr_cyc - par_cyc) >= GAP + 2}, 32'd1);
      wait_done();

      // async reset mid-payload
      send_cmd(2'd0, 6'd10, 8'h40, 1'b0);
      n = 0;
      while (!(in_pkt && exp_q.size() < 8) && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("mid_payload_valid", {31'd0, pkt_valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check_val("arst_data_out", {24'd0, data_out}, 32'd0);
      check_val("arst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check_val("arst_tx_done", {31'd0, tx_done}, 32'd0);
      check_val("arst_cmd_err", {31'd0, cmd_err}, 32'd0);
      check_val("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("arst_pkt_count", {16'd0, pkt_count}, 32'd0);
      exp_q.delete();
      in_pkt = 1'b0;
      hdr_noted = 1'b0;
      tx_exp = 1'b0;
      model_cnt = '0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      @(posedge clock); #1;
      check_val("post_rst_idle_valid", {31'd0, pkt_valid}, 32'd0);
      send_cmd(2'd1, 6'd1, 8'hA5, 1'b0);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
